// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage: default geometry and
// op_b source-select encodings.
package alu_operand_stage_pkg;

    localparam int DATA_W_DEFAULT     = 64;
    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int NUM_FWD_DEFAULT    = 2;

    localparam logic [1:0] SRC_REG  = 2'b00;
    localparam logic [1:0] SRC_IMM  = 2'b01;
    localparam logic [1:0] SRC_PC   = 2'b10;
    localparam logic [1:0] SRC_ZERO = 2'b11;

    // A source may forward only to a real (non-x0) register it actually writes.
    function automatic logic fwd_eligible(input logic fwd_v, input logic addr_eq, input logic rs_nonzero);
        return fwd_v & addr_eq & rs_nonzero;
    endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// Priority forwarding selector: the youngest (lowest index) matching
// downstream stage supplies the operand, otherwise the register file does.
module alu_operand_stage_fwd_select
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int NUM_FWD    = NUM_FWD_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0]         i_rs_addr,
    input  logic [DATA_W-1:0]             i_reg,
    input  logic [NUM_FWD-1:0]            i_fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] i_fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0]     i_fwd_data,
    output logic [DATA_W-1:0]             o_data,
    output logic [NUM_FWD-1:0]            o_hit
);

    logic rs_nonzero;
    logic found;

    assign rs_nonzero = (i_rs_addr != {REG_ADDR_W{1'b0}});

    // Scan from youngest to oldest; the first eligible match locks the result.
    always_comb begin
        o_data = i_reg;
        o_hit  = {NUM_FWD{1'b0}};
        found  = 1'b0;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (!found && fwd_eligible(i_fwd_valid[k],
                                       i_fwd_addr[k*REG_ADDR_W +: REG_ADDR_W] == i_rs_addr,
                                       rs_nonzero)) begin
                found    = 1'b1;
                o_data   = i_fwd_data[k*DATA_W +: DATA_W];
                o_hit[k] = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU op_b operand stage: source mux with forwarding, registered in a
// one-entry valid/ready slot between decode and the ALU.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int NUM_FWD    = NUM_FWD_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [1:0]                    i_src_sel,
    input  logic [REG_ADDR_W-1:0]         i_rs_addr,
    input  logic [DATA_W-1:0]             i_reg,
    input  logic [DATA_W-1:0]             i_imm,
    input  logic [DATA_W-1:0]             i_pc,
    input  logic [NUM_FWD-1:0]            i_fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] i_fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0]     i_fwd_data,
    input  logic                          i_flush,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [DATA_W-1:0]             o_alu_b,
    output logic [NUM_FWD-1:0]            o_fwd_hit
);

    logic [DATA_W-1:0]  fwd_data;
    logic [NUM_FWD-1:0] fwd_hit;
    logic [DATA_W-1:0]  sel_data;
    logic [NUM_FWD-1:0] sel_hit;
    logic               load;

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [NUM_FWD-1:0] hit_q,   hit_d;

    alu_operand_stage_fwd_select #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) u_fwd_select (
        .i_rs_addr   (i_rs_addr),
        .i_reg       (i_reg),
        .i_fwd_valid (i_fwd_valid),
        .i_fwd_addr  (i_fwd_addr),
        .i_fwd_data  (i_fwd_data),
        .o_data      (fwd_data),
        .o_hit       (fwd_hit)
    );

    // Source mux; only the register path can report a forwarding hit.
    always_comb begin
        sel_data = {DATA_W{1'b0}};
        sel_hit  = {NUM_FWD{1'b0}};
        case (i_src_sel)
            SRC_REG: begin
                sel_data = fwd_data;
                sel_hit  = fwd_hit;
            end
            SRC_IMM:  sel_data = i_imm;
            SRC_PC:   sel_data = i_pc;
            SRC_ZERO: sel_data = {DATA_W{1'b0}};
            default:  sel_data = {DATA_W{1'b0}};
        endcase
    end

    assign o_ready = !valid_q || i_ready;
    assign load    = i_valid && o_ready && !i_flush;

    // Next state: capture once on load; data and hit hold otherwise.
    always_comb begin
        valid_d = valid_q;
        alu_b_d = alu_b_q;
        hit_d   = hit_q;
        if (load) begin
            valid_d = 1'b1;
            alu_b_d = sel_data;
            hit_d   = sel_hit;
        end else if (i_flush || i_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            alu_b_q <= {DATA_W{1'b0}};
            hit_q   <= {NUM_FWD{1'b0}};
        end else begin
            valid_q <= valid_d;
            alu_b_q <= alu_b_d;
            hit_q   <= hit_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_alu_b   = alu_b_q;
    assign o_fwd_hit = hit_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a
// randomized run against a behavioural transaction-level model.
module tb_alu_operand_stage;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NF = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid, o_ready, i_flush, o_valid, i_ready;
    logic [1:0]    i_src_sel;
    logic [AW-1:0] i_rs_addr;
    logic [DW-1:0] i_reg, i_imm, i_pc, o_alu_b;
    logic [NF-1:0] i_fwd_valid, o_fwd_hit;
    logic [AW-1:0] fa [NF];
    logic [DW-1:0] fd [NF];
    logic [NF*AW-1:0] i_fwd_addr;
    logic [NF*DW-1:0] i_fwd_data;

    int tests = 0;
    int fails = 0;

    // Reference model state: what the stage should currently present.
    logic          exp_valid;
    logic [DW-1:0] exp_b;
    logic [NF-1:0] exp_hit;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NF; g++) begin : g_pack
        assign i_fwd_addr[g*AW +: AW] = fa[g];
        assign i_fwd_data[g*DW +: DW] = fd[g];
    end

    alu_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_FWD(NF)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_src_sel(i_src_sel), .i_rs_addr(i_rs_addr), .i_reg(i_reg),
        .i_imm(i_imm), .i_pc(i_pc), .i_fwd_valid(i_fwd_valid),
        .i_fwd_addr(i_fwd_addr), .i_fwd_data(i_fwd_data), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_alu_b(o_alu_b), .o_fwd_hit(o_fwd_hit)
    );

    // Operand the architecture asks for given the current inputs.
    function automatic void ref_operand(output logic [DW-1:0] d, output logic [NF-1:0] h);
        d = '0;
        h = '0;
        if (i_src_sel == 2'd1) d = i_imm;
        else if (i_src_sel == 2'd2) d = i_pc;
        else if (i_src_sel == 2'd3) d = '0;
        else begin
            d = i_reg;
            if (i_rs_addr != 0) begin
                for (int k = NF - 1; k >= 0; k--)
                    if (i_fwd_valid[k] && fa[k] == i_rs_addr) begin
                        d = fd[k];
                        h = '0;
                        h[k] = 1'b1;
                    end
            end
        end
    endfunction

    // Advance one clock, updating the model with the transfer that edge performs.
    task automatic tick();
        logic [DW-1:0] d;
        logic [NF-1:0] h;
        logic accept, take;
        accept = !exp_valid || i_ready;
        take   = i_valid && accept && !i_flush;
        ref_operand(d, h);
        @(posedge clk);
        #1;
        if (take) begin
            exp_valid = 1'b1;
            exp_b     = d;
            exp_hit   = h;
        end else if (i_flush || i_ready || !exp_valid) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0; i_src_sel = 2'b00;
        i_rs_addr = '0; i_reg = '0; i_imm = '0; i_pc = '0; i_fwd_valid = '0;
        for (int k = 0; k < NF; k++) begin fa[k] = '0; fd[k] = '0; end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        exp_valid = 1'b0; exp_b = '0; exp_hit = '0;
        #12;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        tests++; if (o_alu_b !== 64'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", o_alu_b); end
        tests++; if (o_fwd_hit !== 2'b00) begin fails++; $display("FAIL reset_hit: got %b expected 00", o_fwd_hit); end
        tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_imm();
        i_src_sel = 2'b01; i_imm = 64'h0000_0000_0000_00FF; i_valid = 1'b1; i_ready = 1'b1;
        i_fwd_valid = 2'b11; fa[0] = 5'd0; fd[0] = 64'hBAD;
        tick();
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL imm_valid: got %b expected 1", o_valid); end
        tests++; if (o_alu_b !== 64'hFF) begin fails++; $display("FAIL imm_data: got %h expected ff", o_alu_b); end
        tests++; if (o_fwd_hit !== 2'b00) begin fails++; $display("FAIL imm_hit: got %b expected 00", o_fwd_hit); end
        i_valid = 1'b0;
        tick();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b expected 0", o_valid); end
        tests++; if (o_alu_b !== 64'hFF) begin fails++; $display("FAIL drain_hold: got %h expected ff", o_alu_b); end
    endtask

    task automatic test_fwd_priority();
        i_src_sel = 2'b00; i_rs_addr = 5'd5; i_reg = 64'h11; i_valid = 1'b1; i_ready = 1'b1;
        i_fwd_valid = 2'b11; fa[0] = 5'd5; fd[0] = 64'hAA; fa[1] = 5'd5; fd[1] = 64'hBB;
        tick();
        tests++; if (o_alu_b !== 64'hAA) begin fails++; $display("FAIL fwd0_data: got %h expected aa", o_alu_b); end
        tests++; if (o_fwd_hit !== 2'b01) begin fails++; $display("FAIL fwd0_hit: got %b expected 01", o_fwd_hit); end
        i_fwd_valid = 2'b10;
        tick();
        tests++; if (o_alu_b !== 64'hBB) begin fails++; $display("FAIL fwd1_data: got %h expected bb", o_alu_b); end
        tests++; if (o_fwd_hit !== 2'b10) begin fails++; $display("FAIL fwd1_hit: got %b expected 10", o_fwd_hit); end
        i_fwd_valid = 2'b11; fa[0] = 5'd6; fa[1] = 5'd7;
        tick();
        tests++; if (o_alu_b !== 64'h11) begin fails++; $display("FAIL nomatch_data: got %h expected 11", o_alu_b); end
        tests++; if (o_fwd_hit !== 2'b00) begin fails++; $display("FAIL nomatch_hit: got %b expected 00", o_fwd_hit); end
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b expected 1", o_valid); end
    endtask

    task automatic test_zero_addr();
        i_src_sel = 2'b00; i_rs_addr = 5'd0; i_reg = 64'h0; i_valid = 1'b1; i_ready = 1'b1;
        i_fwd_valid = 2'b11; fa[0] = 5'd0; fd[0] = 64'hDEAD; fa[1] = 5'd0; fd[1] = 64'hBEEF;
        tick();
        tests++; if (o_alu_b !== 64'h0) begin fails++; $display("FAIL x0_data: got %h expected 0", o_alu_b); end
        tests++; if (o_fwd_hit !== 2'b00) begin fails++; $display("FAIL x0_hit: got %b expected 00", o_fwd_hit); end
    endtask

    task automatic test_backpressure();
        i_src_sel = 2'b01; i_imm = 64'h1; i_valid = 1'b1; i_ready = 1'b1; i_fwd_valid = '0;
        tick();
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_imm = {$urandom, $urandom}; i_src_sel = 2'($urandom_range(0, 3));
            i_rs_addr = 5'd9; i_fwd_valid = 2'b11; fa[0] = 5'd9; fd[0] = {$urandom, $urandom};
            tick();
            tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, o_valid); end
            tests++; if (o_alu_b !== 64'h1) begin fails++; $display("FAIL stall_data[%0d]: got %h expected 1", c, o_alu_b); end
            tests++; if (o_fwd_hit !== 2'b00) begin fails++; $display("FAIL stall_hit[%0d]: got %b expected 00", c, o_fwd_hit); end
            tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %b expected 0", c, o_ready); end
        end
        i_ready = 1'b1; i_src_sel = 2'b01; i_imm = 64'h2;
        #1;
        tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b expected 1", o_ready); end
        tick();
        tests++; if (o_alu_b !== 64'h2) begin fails++; $display("FAIL release_data: got %h expected 2", o_alu_b); end
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL release_valid: got %b expected 1", o_valid); end
    endtask

    task automatic test_flush();
        i_src_sel = 2'b01; i_imm = 64'h7; i_valid = 1'b1; i_ready = 1'b1; i_fwd_valid = '0;
        tick();
        i_ready = 1'b0; i_flush = 1'b1; i_imm = 64'h3;
        tick();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", o_valid); end
        tests++; if (o_alu_b !== 64'h7) begin fails++; $display("FAIL flush_data: got %h expected 7", o_alu_b); end
        i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        tick();
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL post_flush_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_async_reset();
        i_src_sel = 2'b00; i_rs_addr = 5'd3; i_reg = 64'h5;
        i_fwd_valid = 2'b10; fa[1] = 5'd3; fd[1] = 64'hCAFE; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        tick();
        tests++; if (o_fwd_hit !== 2'b10) begin fails++; $display("FAIL prerst_hit: got %b expected 10", o_fwd_hit); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b expected 0", o_valid); end
        tests++; if (o_alu_b !== 64'h0) begin fails++; $display("FAIL arst_data: got %h expected 0", o_alu_b); end
        tests++; if (o_fwd_hit !== 2'b00) begin fails++; $display("FAIL arst_hit: got %b expected 00", o_fwd_hit); end
        exp_valid = 1'b0; exp_b = '0; exp_hit = '0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 9) == 0);
            i_src_sel = 2'($urandom_range(0, 3));
            i_rs_addr = 5'($urandom_range(0, 3));
            i_reg = {$urandom, $urandom}; i_imm = {$urandom, $urandom}; i_pc = {$urandom, $urandom};
            i_fwd_valid = 2'($urandom_range(0, 3));
            for (int k = 0; k < NF; k++) begin
                fa[k] = 5'($urandom_range(0, 3));
                fd[k] = {$urandom, $urandom};
            end
            #1;
            tests++; if (o_ready !== (!exp_valid || i_ready)) begin fails++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, o_ready, !exp_valid || i_ready); end
            tick();
            tests++; if (o_valid !== exp_valid) begin fails++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, o_valid, exp_valid); end
            if (exp_valid) begin
                tests++; if (o_alu_b !== exp_b) begin fails++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, o_alu_b, exp_b); end
                tests++; if (o_fwd_hit !== exp_hit) begin fails++; $display("FAIL rnd_hit[%0d]: got %b expected %b", c, o_fwd_hit, exp_hit); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_imm();
        test_fwd_priority();
        test_zero_addr();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
